multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath: one memory port, one ALU, and the 32-bit 2:1/3:1 select muxes that feed them. Drives every select and write-enable from the current state plus the decoded opcode, funct3, funct7[5] and the ALU zero flag.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Memory accesses wait on a ready handshake.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP and holds there. 0: it returns to FETCH and the instruction is skipped.
- STATE_W, 4, width of the state register; the 12 states fit in 4 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag, valid in the cycle it is sampled
- mem_ready  input  1  memory has completed the access presented this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address mux select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  enable for the instruction register and OldPC
- reg_write  output  1  register file write enable
- result_src  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  output  2  ALU A select: 00 PC, 01 OldPC, 10 RD1
- alu_src_b  output  2  ALU B select: 00 RD2, 01 ImmExt, 10 constant 4
- imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal  output  1  high while in TRAP

Behaviour:
- Output timing:
  - Moore outputs decode combinationally from the registered state.
  - alu_control additionally depends on funct3/funct7b5/op.
  - pc_write = pc_update | (branch & zero).
  - imm_src is combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Reset: on the clk edge with reset=1, state <= FETCH. While reset=1, pc_write, ir_write, mem_write, reg_write, instr_done and illegal are forced to 0. After release, the first cycle is FETCH.
- Defaults in every state: all enables 0, all selects 00, alu_op 00 (add).
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write=1 and pc_update=1 only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> TRAP if TRAP_ON_ILLEGAL=1, else FETCH with instr_done=1.
- MEMADR: alu_src_a=10, alu_src_b=01. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00.
  - mem_write=1 in every cycle spent in this state.
  - Hold until mem_ready=1; in that cycle instr_done=1, then go to FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1 -> ALUWB. The PC takes the target held in ALUOut; rd gets OldPC+4.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1 -> FETCH.
- TRAP: illegal=1 and all enables 0. Leaves only on reset.
- ALU decode:
  - alu_op 00 -> 000; alu_op 01 -> 001.
  - alu_op 10 decodes funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000 (addi is never a sub)
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - any other funct3 -> 000
- Cycle counts with mem_ready tied high: R/I 4, lw 5, sw 4, beq 3, jal 4.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle; the outputs stay stable during the wait.
- Reset mid-instruction: the next state is FETCH. No write enable is asserted in the reset cycle.
- No other state is reachable. Any unused encoding decodes to FETCH with all enables 0.

Test Plan:
- Reset 2 cycles, mem_ready=1, op=0110011, funct3=000, funct7b5=1 (sub) -> states FETCH, DECODE, EXECUTER, ALUWB. alu_control=001 in EXECUTER; reg_write=1 and instr_done=1 only in ALUWB.
- op=0010011, funct3=000, funct7b5=1 (addi) -> alu_control=000 in EXECUTEI, alu_src_b=01; 4 cycles total.
- op=0000011 (lw) with mem_ready low for 3 cycles in MEMREAD -> adr_src=1 held 4 cycles, then MEMWB with result_src=01 and reg_write=1; 8 cycles total.
- op=0100011 (sw) with mem_ready=0 for 2 cycles -> mem_write=1 for 3 consecutive cycles, instr_done in the last; imm_src=01.
- op=1100011 with zero=1 -> pc_write=1 in BEQ. Repeat with zero=0 -> pc_write=0 in BEQ. Both return to FETCH after 3 cycles.
- op=0000000, TRAP_ON_ILLEGAL=1 -> illegal=1 from the cycle after DECODE and held 10 cycles. Then assert reset in a MEMREAD cycle of a later lw -> next state is FETCH and no enables are asserted during reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared memory
// port, ALU and datapath muxes for lw, sw, R/I-type ALU, beq and jal.
`timescale 1ns/1ps
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int STATE_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [STATE_W-1:0] state_q, state_d;
    logic               pc_update;
    logic               branch;
    logic [1:0]         alu_op;

    // NOTE: reset is sampled on the clock edge only; the state register is the sole flop.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop sees pre-edge values regardless of block order.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is formed here so BEQ/JAL can use ALUOut later.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d    = S_FETCH;
                            instr_done = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC loads the target from ALUOut while the ALU computes OldPC+4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase

        pc_write = pc_update | (branch & zero);

        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                // Only register-register add with funct7[5] set is a subtract.
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule
